// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states
// and small op-classification helpers.
package mul_div_unit_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MADD  = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Code 7 is reserved and behaves like NONE
  function automatic logic op_valid(input logic [2:0] op);
    return (op != OP_NONE) && (op != OP_RSVD);
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle on magnitudes through
// a single shared add/subtract path, sign fix-up and commit in a final FIX cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [1:0]     state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic           sgn_q, sgn_d;
  logic           rneg_q, rneg_d;
  logic           bz_q, bz_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   mcd_q, mcd_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dz_q, dz_d;

  // Operand magnitudes for the incoming request
  logic           in_signed, a_neg, b_neg;
  logic [W-1:0]   mag_a, mag_b;

  assign in_signed = op_signed(op);
  assign a_neg     = in_signed & a[W-1];
  assign b_neg     = in_signed & b[W-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;

  // Shared adder: partial-product add for multiply, trial subtract for divide
  logic           calc_div;
  logic [W:0]     add_x, add_y;
  logic [W+1:0]   add_r;
  logic [2*W-1:0] step_acc;

  assign calc_div = op_is_div(op_q);
  assign add_x    = calc_div ? {acc_q[2*W-1:W], acc_q[W-1]} : {1'b0, acc_q[2*W-1:W]};
  assign add_y    = (calc_div || acc_q[0]) ? {1'b0, mcd_q} : '0;
  assign add_r    = calc_div ? ({1'b0, add_x} - {1'b0, add_y})
                             : ({1'b0, add_x} + {1'b0, add_y});

  // Divide keeps remainder in the upper half and shifts quotient bits into the lower
  always_comb begin
    step_acc = acc_q;
    if (calc_div) begin
      if (!add_r[W+1]) step_acc = {add_r[W-1:0], acc_q[W-2:0], 1'b1};
      else             step_acc = {add_x[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      step_acc = {add_r[W:0], acc_q[W-1:1]};
    end
  end

  // Signed fix-up of the unsigned core results
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quot_s, rem_s;

  assign prod_s = sgn_q ? -acc_q : acc_q;
  assign quot_s = bz_q ? '1 : (sgn_q ? -acc_q[W-1:0] : acc_q[W-1:0]);
  assign rem_s  = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sgn_d   = sgn_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    cnt_d   = cnt_q;
    mcd_d   = mcd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !cancel && op_valid(op)) begin
          state_d = ST_CALC;
          op_d    = op;
          cnt_d   = '0;
          sgn_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          bz_d    = (b == '0);
          if (op_is_div(op)) begin
            acc_d = {{W{1'b0}}, mag_a};
            mcd_d = mag_b;
          end else begin
            acc_d = {{W{1'b0}}, mag_b};
            mcd_d = mag_a;
          end
        end else if (!start) begin
          if (wr_hi) hi_d = wdata;
          if (wr_lo) lo_d = wdata;
        end
      end
      ST_CALC: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          case (op_q)
            OP_MULT, OP_MULTU: {hi_d, lo_d} = prod_s;
            OP_MADD:           {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            OP_MSUB:           {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
            OP_DIV, OP_DIVU: begin
              lo_d = quot_s;
              hi_d = rem_s;
              dz_d = bz_q;
            end
            default: done_d = 1'b0;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      sgn_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      cnt_q   <= '0;
      mcd_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      cnt_q   <= cnt_d;
      mcd_q   <= mcd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width; legal values are even and >= 4.
REQ-002 The block shall use one clock and one reset: reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 res_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  request to begin an operation; sampled only in IDLE.
REQ-006 op  in  3  operation code (MDU_OP), sampled with start.
REQ-007 a  in  WIDTH  operand A (multiplicand or dividend), sampled with start.
REQ-008 b  in  WIDTH  operand B (multiplier or divisor), sampled with start.
REQ-009 cancel  in  1  flush of the in-flight operation (exception path).
REQ-010 wr_hi  in  1  load HI from wdata.
REQ-011 wr_lo  in  1  load LO from wdata.
REQ-012 wdata  in  WIDTH  write data for wr_hi/wr_lo.
REQ-013 busy  out  1  high in CALC and FIX states.
REQ-014 done  out  1  one-cycle registered pulse: the result has been committed to HI/LO.
REQ-015 div_zero  out  1  sticky flag: the last completed division had b == 0.
REQ-016 hi  out  WIDTH  HI register.
REQ-017 lo  out  WIDTH  LO register.

Function
REQ-018 MDU_OP encoding shall be:
- NONE = 0, MULT = 1, MULTU = 2, DIV = 3, DIVU = 4, MADD = 5, MSUB = 6.
- Code 7 is reserved and treated as NONE.
REQ-019 The FSM shall have three states:
- IDLE -> CALC on start with a valid op and cancel low.
- CALC -> FIX after WIDTH iterations.
- FIX -> IDLE always.
REQ-020 Signed ops (MULT, DIV, MADD, MSUB) shall latch operand magnitudes and the result sign at accept; the unsigned core iterates one bit per cycle.
REQ-021 Multiply shall use shift-add: after WIDTH CALC cycles the 2*WIDTH product is unsigned; FIX negates it if the sign flag is set.
REQ-022 Divide shall use restoring shift-subtract, one quotient bit per CALC cycle. FIX shall:
- negate the quotient if the operand signs differ;
- give the remainder the sign of the dividend.
REQ-023 Commit shall happen at the FIX-exit edge:
- MULT/MULTU: {hi,lo} = product.
- DIV/DIVU: lo = quotient, hi = remainder.
- MADD: {hi,lo} += signed product, modulo 2^(2*WIDTH).
- MSUB: {hi,lo} -= signed product, modulo 2^(2*WIDTH).
REQ-024 Latency shall be: start accepted at edge 0; done high during the cycle following edge WIDTH+1; hi/lo valid in that same cycle.
REQ-025 done shall be asserted for exactly one cycle per committed operation and never for a cancelled one.
REQ-026 Division by zero shall complete with normal latency:
- lo = all ones, hi = dividend (a unchanged, unsigned bit pattern);
- div_zero set at commit.
REQ-027 div_zero shall be cleared at the commit of any division with a nonzero divisor, and is unaffected by multiplies.
REQ-028 Signed overflow DIV (a = most-negative, b = -1) shall give lo = most-negative and hi = 0, with no flag.
REQ-029 start while busy shall be ignored. start with op NONE or reserved shall be ignored; no done is produced.
REQ-030 cancel while busy shall return the FSM to IDLE at the next edge. hi, lo and div_zero are unchanged and no done is produced.
REQ-031 cancel and start in the same IDLE cycle: start shall be ignored.
REQ-032 wr_hi/wr_lo shall take effect at the next edge only in IDLE with start low. They are dropped while busy or when start is accepted in the same cycle.
REQ-033 MADD/MSUB shall use the hi/lo values present at the commit edge. Writes cannot intervene, per REQ-032.
REQ-034 A new start shall be accepted in the same cycle that done is high; the block is back-to-back capable.

Reset
REQ-035 While res_n is low, all registers shall take these values:
- FSM = IDLE;
- busy = 0, done = 0, div_zero = 0;
- hi = 0, lo = 0;
- internal operand and accumulator registers = 0.
REQ-036 Reset asserted mid-operation shall discard the operation. No done is issued after reset release.

Structure
REQ-037 MDU_OP codes and width shall be defined in the shared header mdu.vh, alongside ALUOp/opcode headers, for use by the Controller.
REQ-038 The block shall be a single module with no sub-module: one shared WIDTH+1 adder/subtractor serves both multiply and divide.

Verification
REQ-039 WIDTH=32, MULT a=32'hFFFFFFFF b=2 -> done exactly 33 cycles after accept, hi=32'hFFFFFFFF, lo=32'hFFFFFFFE.
REQ-040 DIVU a=100 b=7 -> lo=14, hi=2. DIV a=-7 b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF, div_zero=0.
REQ-041 DIV a=5 b=0 -> hi=5, lo=32'hFFFFFFFF, div_zero=1. Next DIVU 9/3 -> lo=3, hi=0, div_zero=0.
REQ-042 wr_hi 0, wr_lo 10, then MADD a=3 b=4 -> lo=22. Then MSUB a=-2 b=5 -> lo=32, hi=0.
REQ-043 MULTU started, cancel at CALC cycle 10 -> busy low next cycle, no done, hi/lo unchanged. wr_hi and start while busy are ignored.
REQ-044 WIDTH=8, MULT a=8'h80 b=8'h80 -> {hi,lo}=16'h4000 after 9 cycles. res_n pulsed low mid-CALC -> all outputs 0, no done.
